// File: rtl/rs232_pkg.sv
// rtl/rs232_pkg.sv - shared types and constants for the rs232 transmit arbiter
package rs232_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        ISSUE,
        WAIT_START,
        WAIT_DONE
    } state_t;

    localparam int UART_DATA_W       = 8;
    localparam int DEF_START_TIMEOUT = 16;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting after the pointer
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [$clog2(NUM_REQ)-1:0] winner,
    output logic                       any_valid
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] cand;

    // Walk from farthest to nearest so the nearest valid index after ptr wins.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        cand      = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (req[cand]) begin
                winner    = cand;
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rs232_tx_arbiter.sv
// rtl/rs232_tx_arbiter.sv - round-robin sharing of one rs232_tx; RS232_TX_ARB_LOCK_EN adds req_lock
module rs232_tx_arbiter
    import rs232_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int DATA_W        = UART_DATA_W,
    parameter int START_TIMEOUT = DEF_START_TIMEOUT
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
`ifdef RS232_TX_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]         req_lock,
`endif
    output logic [NUM_REQ-1:0]         req_ack,
    output logic [DATA_W-1:0]          tx_data_in,
    output logic                       tx_data_flag,
    input  logic                       flag_txe,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       err_timeout
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(START_TIMEOUT + 1);

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] rr_winner;
    logic [IDX_W-1:0] sel;
    logic             any_valid;
    logic             use_lock;
    logic             sel_valid;
    logic [CNT_W-1:0] wait_cnt;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_rr (
        .req      (req_valid),
        .ptr      (rr_ptr),
        .winner   (rr_winner),
        .any_valid(any_valid)
    );

`ifdef RS232_TX_ARB_LOCK_EN
    logic lock_hold;
    // A held lock only sticks while the owner still asserts both lock and valid.
    assign use_lock = lock_hold && req_lock[grant_id] && req_valid[grant_id];
`else
    assign use_lock = 1'b0;
`endif

    assign sel       = use_lock ? grant_id : rr_winner;
    assign sel_valid = use_lock | any_valid;
    assign busy      = (state != IDLE);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state        <= IDLE;
            req_ack      <= '0;
            tx_data_in   <= '0;
            tx_data_flag <= 1'b0;
            grant_id     <= '0;
            err_timeout  <= 1'b0;
            rr_ptr       <= IDX_W'(NUM_REQ - 1);
            wait_cnt     <= '0;
`ifdef RS232_TX_ARB_LOCK_EN
            lock_hold    <= 1'b0;
`endif
        end else begin
            req_ack      <= '0;
            tx_data_flag <= 1'b0;
            err_timeout  <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req_valid && flag_txe) state <= GRANT;
                end
                GRANT: begin
                    // Requests withdrawn before the grant are dropped silently.
                    if (sel_valid) begin
                        req_ack    <= NUM_REQ'(1) << sel;
                        tx_data_in <= DATA_W'(req_data >> (int'(sel) * DATA_W));
                        grant_id   <= sel;
                        rr_ptr     <= sel;
                        state      <= ISSUE;
                    end else begin
                        state <= IDLE;
                    end
                end
                ISSUE: begin
                    tx_data_flag <= 1'b1;
                    wait_cnt     <= '0;
                    state        <= WAIT_START;
                end
                WAIT_START: begin
                    if (!flag_txe) begin
                        state <= WAIT_DONE;
                    end else if (wait_cnt == CNT_W'(START_TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        state       <= IDLE;
`ifdef RS232_TX_ARB_LOCK_EN
                        lock_hold   <= 1'b0;
`endif
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                WAIT_DONE: begin
                    if (flag_txe) begin
                        state     <= IDLE;
`ifdef RS232_TX_ARB_LOCK_EN
                        lock_hold <= req_lock[grant_id];
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// tb/tb_rs232_tx_arbiter.sv - randomized self-checking bench for rs232_tx_arbiter
module tb_rs232_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;
`ifdef RS232_TX_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           sys_rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*8-1:0] req_data = '0;
    logic [N-1:0]   req_lock = '0;
    logic           flag_txe = 1'b1;
    logic [N-1:0]   req_ack;
    logic [7:0]     tx_data_in;
    logic           tx_data_flag;
    logic [1:0]     grant_id;
    logic           busy;
    logic           err_timeout;

    rs232_tx_arbiter #(
        .NUM_REQ(N), .DATA_W(8), .START_TIMEOUT(TO)
    ) dut (
        .sys_clk     (clk),
        .sys_rst     (sys_rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
`ifdef RS232_TX_ARB_LOCK_EN
        .req_lock    (req_lock),
`endif
        .req_ack     (req_ack),
        .tx_data_in  (tx_data_in),
        .tx_data_flag(tx_data_flag),
        .flag_txe    (flag_txe),
        .grant_id    (grant_id),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit         pend[N];
    bit         lk[N];
    logic [7:0] byte_of[N];
    int         mptr;
    bit         cont;
    bit         stuck;
    int         tx_delay, tx_low;
    int         n_acks, n_flags, n_err;
    int         ack_log[$];
    logic [7:0] flag_log[$];
    logic [7:0] exp_bytes[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        req_valid = '0;
        req_data  = '0;
        req_lock  = '0;
        for (int i = 0; i < N; i++) begin
            if (pend[i]) req_valid = req_valid | (N'(1) << i);
            if (lk[i])   req_lock  = req_lock  | (N'(1) << i);
            req_data = req_data | ((N*8)'(byte_of[i]) << (8 * i));
        end
    endtask

    // Next owner: a locked, still-valid previous owner keeps the channel,
    // otherwise the first pending requester after the last grant.
    function automatic int exp_winner();
        if (LOCK_EN && lk[mptr] && pend[mptr]) return mptr;
        for (int k = 1; k <= N; k++)
            if (pend[(mptr + k) % N]) return (mptr + k) % N;
        return -1;
    endfunction

    task automatic step();
        int w;
        int obs;
        @(negedge clk);
        if (tx_delay > 0) begin
            tx_delay--;
            if (tx_delay == 0) begin
                flag_txe = 1'b0;
                tx_low   = 10;
            end
        end else if (tx_low > 0) begin
            tx_low--;
            if (tx_low == 0) flag_txe = 1'b1;
        end
        if (tx_data_flag) begin
            n_flags++;
            flag_log.push_back(tx_data_in);
            if (exp_bytes.size() == 0) chk("flag_without_ack", 1, 0);
            else chk("tx_byte", tx_data_in, exp_bytes.pop_front());
            if (!stuck) tx_delay = 2;
        end
        if (err_timeout) n_err++;
        if (req_ack != '0) begin
            w   = exp_winner();
            obs = 0;
            for (int k = 0; k < N; k++) if (((req_ack >> k) & N'(1)) != '0) obs = k;
            chk("ack_flag_excl", tx_data_flag, 0);
            chk("ack_onehot", req_ack, (w < 0) ? 0 : (1 << w));
            chk("grant_id", grant_id, w);
            n_acks++;
            ack_log.push_back(obs);
            exp_bytes.push_back(byte_of[obs]);
            mptr = (w < 0) ? obs : w;
            if (!cont) begin
                pend[obs] = 1'b0;
                drive();
            end
        end
    endtask

    task automatic run_until_acks(input int target, input int budget);
        int c = 0;
        while (n_acks < target && c < budget) begin step(); c++; end
        chk("ack_budget", n_acks >= target, 1);
    endtask

    task automatic run_until_flags(input int target, input int budget);
        int c = 0;
        while (n_flags < target && c < budget) begin step(); c++; end
        chk("flag_budget", n_flags >= target, 1);
    endtask

    task automatic run_until_idle(input int budget);
        int c = 0;
        step();
        while ((busy || !flag_txe || tx_delay > 0 || tx_low > 0) && c < budget) begin
            step();
            c++;
        end
        chk("idle_budget", c < budget, 1);
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            lk[i]   = 1'b0;
        end
        drive();
    endtask

    task automatic do_reset();
        clear_reqs();
        cont = 1'b0; stuck = 1'b0;
        tx_delay = 0; tx_low = 0; flag_txe = 1'b1;
        sys_rst = 1'b1;
        step(); step();
        sys_rst = 1'b0;
        mptr = N - 1;
        n_acks = 0; n_flags = 0; n_err = 0;
        ack_log.delete(); flag_log.delete(); exp_bytes.delete();
    endtask

    initial begin
        int cnt;
        int base;
        int exp_seq[5];
        int exp_lock[4];
        for (int i = 0; i < N; i++) byte_of[i] = 8'h00;

        do_reset();
        chk("rst_ack", req_ack, 0);
        chk("rst_data", tx_data_in, 0);
        chk("rst_flag", tx_data_flag, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_timeout, 0);

        // Single requester
        byte_of[2] = 8'h0F; pend[2] = 1'b1; drive();
        run_until_acks(1, 50);
        run_until_idle(100);
        chk("single_acks", n_acks, 1);
        chk("single_who", ack_log[0], 2);
        chk("single_flags", n_flags, 1);
        chk("single_data", tx_data_in, 8'h0F);
        chk("single_busy", busy, 0);

        // All four continuously valid
        do_reset();
        cont = 1'b1;
        for (int i = 0; i < N; i++) begin byte_of[i] = 8'hA0 + 8'(i); pend[i] = 1'b1; end
        drive();
        run_until_flags(5, 500);
        cont = 1'b0; clear_reqs();
        run_until_idle(100);
        exp_seq = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++) begin
            chk("rr_grant", (ack_log.size() > k) ? ack_log[k] : -1, exp_seq[k]);
            chk("rr_byte", (flag_log.size() > k) ? flag_log[k] : 8'hxx, 8'hA0 + 8'(exp_seq[k]));
        end

        // Late joiner 3 after a grant to 1
        do_reset();
        cont = 1'b1;
        byte_of[1] = 8'h11; byte_of[3] = 8'h33; pend[1] = 1'b1; drive();
        run_until_acks(1, 50);
        pend[3] = 1'b1; drive();
        run_until_acks(3, 300);
        cont = 1'b0; clear_reqs();
        run_until_idle(100);
        chk("join_0", ack_log[0], 1);
        chk("join_1", ack_log[1], 3);
        chk("join_2", ack_log[2], 1);

        // Start timeout
        do_reset();
        stuck = 1'b1;
        byte_of[0] = 8'h5A; pend[0] = 1'b1; drive();
        run_until_flags(1, 50);
        cnt = 0;
        while (!err_timeout && cnt < 40) begin step(); cnt++; end
        chk("timeout_latency", cnt, TO);
        chk("timeout_busy", busy, 0);
        repeat (30) step();
        chk("timeout_acks", n_acks, 1);
        chk("timeout_flags", n_flags, 1);
        chk("timeout_pulses", n_err, 1);
        stuck = 1'b0;

        // Reset while in WAIT_DONE
        do_reset();
        byte_of[3] = 8'h77; pend[3] = 1'b1; drive();
        cnt = 0;
        while (!(busy && !flag_txe) && cnt < 100) begin step(); cnt++; end
        chk("reach_wait_done", cnt < 100, 1);
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
        mptr = N - 1;
        exp_bytes.delete();
        chk("mid_rst_ack", req_ack, 0);
        chk("mid_rst_data", tx_data_in, 0);
        chk("mid_rst_flag", tx_data_flag, 0);
        chk("mid_rst_grant", grant_id, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_err", err_timeout, 0);
        for (int i = 0; i < N; i++) begin byte_of[i] = 8'hB0 + 8'(i); pend[i] = 1'b1; end
        drive();
        base = n_acks;
        run_until_acks(base + 1, 100);
        chk("post_rst_first", ack_log[ack_log.size() - 1], 0);
        run_until_acks(base + 4, 400);
        run_until_idle(100);

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 7) == 0) begin
                    pend[i]    = 1'b1;
                    byte_of[i] = 8'($urandom);
                end
            end
            drive();
        end
        cnt = 0;
        while ((pend[0] || pend[1] || pend[2] || pend[3]) && cnt < 1000) begin step(); cnt++; end
        run_until_idle(100);
        chk("rand_drained", cnt < 1000, 1);
        chk("rand_flags_eq_acks", n_flags, n_acks);
        chk("rand_enough", n_acks > 20, 1);

`ifdef RS232_TX_ARB_LOCK_EN
        do_reset();
        cont = 1'b1;
        byte_of[1] = 8'h31; byte_of[2] = 8'h32;
        pend[1] = 1'b1; pend[2] = 1'b1; lk[1] = 1'b1; drive();
        run_until_acks(3, 300);
        lk[1] = 1'b0; pend[1] = 1'b0; drive();
        run_until_acks(4, 200);
        cont = 1'b0; clear_reqs();
        run_until_idle(100);
        exp_lock = '{1, 1, 1, 2};
        for (int k = 0; k < 4; k++)
            chk("lock_seq", (ack_log.size() > k) ? ack_log[k] : -1, exp_lock[k]);
`else
        exp_lock = '{0, 0, 0, 0};
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
